// File: rtl/game_state_ctrl_if.sv
// Game-state controller bundle: frame/button/event strobes and positions in, mode/score/lives/strobes out.
// master drives the game inputs; slave is the controller side.
interface game_state_ctrl_if #(
   parameter int N_ENEMIES = 4,
   parameter int COORD_W   = 9,
   parameter int SCORE_W   = 16,
   parameter int LIVES     = 3
);
   localparam int LIVES_W = $clog2(LIVES + 1);

   logic                           frame_stb;
   logic [3:0]                     btn;
   logic                           ate_candy_stb;
   logic                           ate_power_stb;
   logic [COORD_W-1:0]             x_pac;
   logic [COORD_W-1:0]             y_pac;
   logic [N_ENEMIES*COORD_W-1:0]   enemy_x;
   logic [N_ENEMIES*COORD_W-1:0]   enemy_y;

   logic [2:0]                     mode;
   logic [2:0]                     sound_type;
   logic [SCORE_W-1:0]             score;
   logic [LIVES_W-1:0]             lives;
   logic                           move_stb;
   logic                           frightened;
   logic [N_ENEMIES-1:0]           enemy_eaten_stb;
   logic                           respawn_stb;

   modport master (
      output frame_stb, btn, ate_candy_stb, ate_power_stb, x_pac, y_pac, enemy_x, enemy_y,
      input  mode, sound_type, score, lives, move_stb, frightened, enemy_eaten_stb, respawn_stb
   );

   modport slave (
      input  frame_stb, btn, ate_candy_stb, ate_power_stb, x_pac, y_pac, enemy_x, enemy_y,
      output mode, sound_type, score, lives, move_stb, frightened, enemy_eaten_stb, respawn_stb
   );
endinterface

// File: rtl/game_state_ctrl.sv
// Game-mode sequencer: LOADING -> READY -> PLAY/BLUE -> FAIL/WIN, with score, lives,
// candy tally, frightened timer, per-frame enemy collision and the gated movement strobe.
module game_state_ctrl #(
   parameter int N_ENEMIES      = 4,
   parameter int COORD_W        = 9,
   parameter int SCORE_W        = 16,
   parameter int CANDY_COUNT    = 244,
   parameter int LIVES          = 3,
   parameter int GHOST_POINTS   = 10,
   parameter int LOADING_FRAMES = 60,
   parameter int FRIGHT_FRAMES  = 360
) (
   input  logic               vga_pix_clk,
   input  logic               rst,
   game_state_ctrl_if.slave   gs
);
   localparam logic [2:0] MODE_LOADING    = 3'd0;
   localparam logic [2:0] MODE_READY      = 3'd1;
   localparam logic [2:0] MODE_GAME_PLAY  = 3'd2;
   localparam logic [2:0] MODE_BLUE_GHOST = 3'd3;
   localparam logic [2:0] MODE_FAIL       = 3'd4;
   localparam logic [2:0] MODE_WIN        = 3'd5;

   localparam logic [2:0] SOUND_LOADING   = 3'd0;
   localparam logic [2:0] SOUND_READY     = 3'd1;
   localparam logic [2:0] SOUND_GAME_PLAY = 3'd2;
   localparam logic [2:0] SOUND_FAIL      = 3'd3;
   localparam logic [2:0] SOUND_WIN       = 3'd4;

   localparam int MAX_FRAMES = (LOADING_FRAMES > FRIGHT_FRAMES) ? LOADING_FRAMES : FRIGHT_FRAMES;
   localparam int CNT_W      = $clog2(MAX_FRAMES + 1);
   localparam int LIVES_W    = $clog2(LIVES + 1);
   localparam int TALLY_W    = $clog2(CANDY_COUNT + 1);
   localparam int ADD_W      = $clog2(GHOST_POINTS * N_ENEMIES + 2);
   localparam int SUM_W      = ((SCORE_W > ADD_W) ? SCORE_W : ADD_W) + 1;
   localparam logic [SUM_W-1:0] SCORE_MAX = (SUM_W'(1) << SCORE_W) - SUM_W'(1);

   logic [2:0]           mode_q, mode_d;
   logic [2:0]           sound_q, sound_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   logic [SCORE_W-1:0]   score_q, score_d;
   logic [LIVES_W-1:0]   lives_q, lives_d;
   logic [TALLY_W-1:0]   tally_q, tally_d;
   logic                 btn_any_q, btn_any_d;
   logic [N_ENEMIES-1:0] eaten_q, eaten_d;
   logic                 respawn_q, respawn_d;

   logic [N_ENEMIES-1:0] hit;
   logic                 key_press, in_play, candy, win;
   int                   n_ghost;
   logic [ADD_W-1:0]     add;
   logic [SUM_W-1:0]     sum;
   logic [SCORE_W-1:0]   score_sat;
   logic [TALLY_W-1:0]   tally_inc;

   // Collisions only count on the frame strobe, so a lingering overlap acts once per frame.
   always_comb begin
      hit     = '0;
      n_ghost = 0;
      for (int i = 0; i < N_ENEMIES; i++) begin
         hit[i] = gs.frame_stb
                  && (gs.x_pac == gs.enemy_x[i*COORD_W +: COORD_W])
                  && (gs.y_pac == gs.enemy_y[i*COORD_W +: COORD_W]);
         if (mode_q == MODE_BLUE_GHOST && hit[i]) n_ghost = n_ghost + 1;
      end
   end

   assign btn_any_d = |gs.btn;
   assign key_press = btn_any_d & ~btn_any_q;
   assign in_play   = (mode_q == MODE_GAME_PLAY) || (mode_q == MODE_BLUE_GHOST);
   assign candy     = in_play & gs.ate_candy_stb;
   assign add       = ADD_W'(GHOST_POINTS * n_ghost) + ADD_W'(candy);
   assign sum       = SUM_W'(score_q) + SUM_W'(add);
   assign score_sat = (sum > SCORE_MAX) ? SCORE_MAX[SCORE_W-1:0] : sum[SCORE_W-1:0];
   assign tally_inc = (candy && tally_q < TALLY_W'(CANDY_COUNT)) ? tally_q + TALLY_W'(1) : tally_q;
   assign win       = candy && (tally_inc >= TALLY_W'(CANDY_COUNT));

   always_comb begin
      mode_d    = mode_q;
      cnt_d     = cnt_q;
      score_d   = score_q;
      lives_d   = lives_q;
      tally_d   = tally_q;
      eaten_d   = '0;
      respawn_d = 1'b0;
      case (mode_q)
         MODE_LOADING: begin
            if (gs.frame_stb) begin
               if (cnt_q == CNT_W'(LOADING_FRAMES - 1)) begin
                  mode_d = MODE_READY;
                  cnt_d  = '0;
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end
         end
         MODE_READY: begin
            if (key_press) begin
               mode_d = MODE_GAME_PLAY;
               cnt_d  = '0;
            end
         end
         MODE_GAME_PLAY: begin
            score_d = score_sat;
            tally_d = tally_inc;
            // WIN outranks a power cookie, which outranks a collision in the same cycle.
            if (win) begin
               mode_d = MODE_WIN;
            end else if (gs.ate_power_stb) begin
               mode_d = MODE_BLUE_GHOST;
               cnt_d  = '0;
            end else if (|hit) begin
               if (lives_q > LIVES_W'(1)) begin
                  lives_d   = lives_q - LIVES_W'(1);
                  respawn_d = 1'b1;
                  mode_d    = MODE_READY;
               end else begin
                  lives_d = '0;
                  mode_d  = MODE_FAIL;
               end
            end
         end
         MODE_BLUE_GHOST: begin
            score_d = score_sat;
            tally_d = tally_inc;
            eaten_d = hit;
            if (win) begin
               mode_d = MODE_WIN;
            end else if (gs.ate_power_stb) begin
               cnt_d = '0;
            end else if (gs.frame_stb) begin
               if (cnt_q == CNT_W'(FRIGHT_FRAMES - 1)) begin
                  mode_d = MODE_GAME_PLAY;
                  cnt_d  = '0;
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end
         end
         MODE_FAIL, MODE_WIN: ;
         default: begin
            mode_d = MODE_LOADING;
            cnt_d  = '0;
         end
      endcase
   end

   always_comb begin
      case (mode_q)
         MODE_READY:                      sound_d = SOUND_READY;
         MODE_GAME_PLAY, MODE_BLUE_GHOST: sound_d = SOUND_GAME_PLAY;
         MODE_FAIL:                       sound_d = SOUND_FAIL;
         MODE_WIN:                        sound_d = SOUND_WIN;
         default:                         sound_d = SOUND_LOADING;
      endcase
   end

   always_ff @(posedge vga_pix_clk) begin
      if (rst) begin
         mode_q    <= MODE_LOADING;
         sound_q   <= SOUND_LOADING;
         cnt_q     <= '0;
         score_q   <= '0;
         lives_q   <= LIVES_W'(LIVES);
         tally_q   <= '0;
         btn_any_q <= 1'b0;
         eaten_q   <= '0;
         respawn_q <= 1'b0;
      end else begin
         mode_q    <= mode_d;
         sound_q   <= sound_d;
         cnt_q     <= cnt_d;
         score_q   <= score_d;
         lives_q   <= lives_d;
         tally_q   <= tally_d;
         btn_any_q <= btn_any_d;
         eaten_q   <= eaten_d;
         respawn_q <= respawn_d;
      end
   end

   assign gs.mode            = mode_q;
   assign gs.sound_type      = sound_q;
   assign gs.score           = score_q;
   assign gs.lives           = lives_q;
   assign gs.move_stb        = gs.frame_stb & in_play;
   assign gs.frightened      = (mode_q == MODE_BLUE_GHOST);
   assign gs.enemy_eaten_stb = eaten_q;
   assign gs.respawn_stb     = respawn_q;
endmodule

// File: tb/tb_game_state_ctrl.sv
// Bench for game_state_ctrl: directed scenarios plus a randomized run against a behavioural model.
module tb_game_state_ctrl;
   localparam int NE = 4, CW = 9, SW = 16, CC = 24, LV = 3, GP = 10, LF = 60, FF = 360;
   localparam int M_LOADING = 0, M_READY = 1, M_PLAY = 2, M_BLUE = 3, M_FAIL = 4, M_WIN = 5;
   localparam int S_LOADING = 0, S_READY = 1, S_PLAY = 2, S_FAIL = 3, S_WIN = 4;

   logic vga_pix_clk = 1'b0;
   logic rst = 1'b1;
   always #5 vga_pix_clk = ~vga_pix_clk;

   logic              frame_stb = 1'b0, ate_candy = 1'b0, ate_power = 1'b0;
   logic [3:0]        btn = 4'd0;
   logic [CW-1:0]     x_pac = 9'd100, y_pac = 9'd100;
   logic [NE*CW-1:0]  enemy_x = '1, enemy_y = '1;

   game_state_ctrl_if #(.N_ENEMIES(NE), .COORD_W(CW), .SCORE_W(SW), .LIVES(LV)) gif ();
   game_state_ctrl_if #(.N_ENEMIES(NE), .COORD_W(CW), .SCORE_W(4),  .LIVES(LV)) gif4 ();

   assign gif.frame_stb  = frame_stb;  assign gif4.frame_stb  = frame_stb;
   assign gif.btn        = btn;        assign gif4.btn        = btn;
   assign gif.ate_candy_stb = ate_candy; assign gif4.ate_candy_stb = ate_candy;
   assign gif.ate_power_stb = ate_power; assign gif4.ate_power_stb = ate_power;
   assign gif.x_pac      = x_pac;      assign gif4.x_pac      = x_pac;
   assign gif.y_pac      = y_pac;      assign gif4.y_pac      = y_pac;
   assign gif.enemy_x    = enemy_x;    assign gif4.enemy_x    = enemy_x;
   assign gif.enemy_y    = enemy_y;    assign gif4.enemy_y    = enemy_y;

   game_state_ctrl #(.N_ENEMIES(NE), .COORD_W(CW), .SCORE_W(SW), .CANDY_COUNT(CC), .LIVES(LV),
                     .GHOST_POINTS(GP), .LOADING_FRAMES(LF), .FRIGHT_FRAMES(FF))
      dut (.vga_pix_clk(vga_pix_clk), .rst(rst), .gs(gif));

   game_state_ctrl #(.N_ENEMIES(NE), .COORD_W(CW), .SCORE_W(4), .CANDY_COUNT(32), .LIVES(LV),
                     .GHOST_POINTS(GP), .LOADING_FRAMES(LF), .FRIGHT_FRAMES(FF))
      dut4 (.vga_pix_clk(vga_pix_clk), .rst(rst), .gs(gif4));

   int n_vec = 0;
   int n_err = 0;

   // Behavioural model: frames left in the current timed phase, plain integer score/lives.
   int          m_mode = M_LOADING, m_sound = S_LOADING, m_score = 0, m_lives = LV;
   int          m_tally = 0, m_timer = LF;
   logic [NE-1:0] m_eaten = '0;
   bit          m_respawn = 0, m_btn_prev = 0;

   function automatic int sound_of(int md);
      case (md)
         M_READY:        return S_READY;
         M_PLAY, M_BLUE: return S_PLAY;
         M_FAIL:         return S_FAIL;
         M_WIN:          return S_WIN;
         default:        return S_LOADING;
      endcase
   endfunction

   task automatic model_update();
      logic [NE-1:0] h;
      int n, sc;
      bit pressed, play, candy;
      h = '0;
      n = 0;
      for (int i = 0; i < NE; i++)
         if (frame_stb && enemy_x[i*CW +: CW] == x_pac && enemy_y[i*CW +: CW] == y_pac) begin
            h[i] = 1'b1;
            n++;
         end
      if (rst) begin
         m_mode = M_LOADING; m_sound = S_LOADING; m_score = 0; m_lives = LV;
         m_tally = 0; m_timer = LF; m_eaten = '0; m_respawn = 0; m_btn_prev = 0;
         return;
      end
      pressed    = (btn != 0) && !m_btn_prev;
      m_btn_prev = (btn != 0);
      m_sound    = sound_of(m_mode);
      m_eaten    = '0;
      m_respawn  = 0;
      play  = (m_mode == M_PLAY) || (m_mode == M_BLUE);
      candy = play && ate_candy;
      if (play) begin
         if (m_mode == M_BLUE) m_eaten = h;
         else n = 0;
         sc = m_score + (candy ? 1 : 0) + GP * n;
         m_score = (sc > 2**SW - 1) ? 2**SW - 1 : sc;
         if (candy && m_tally < CC) m_tally++;
      end
      case (m_mode)
         M_LOADING: if (frame_stb) begin
            m_timer--;
            if (m_timer == 0) m_mode = M_READY;
         end
         M_READY: if (pressed) m_mode = M_PLAY;
         M_PLAY, M_BLUE: begin
            if (candy && m_tally >= CC) m_mode = M_WIN;
            else if (ate_power) begin m_mode = M_BLUE; m_timer = FF; end
            else if (m_mode == M_PLAY && frame_stb && h != 0) begin
               m_lives--;
               if (m_lives == 0) m_mode = M_FAIL;
               else begin m_respawn = 1; m_mode = M_READY; end
            end else if (m_mode == M_BLUE && frame_stb) begin
               m_timer--;
               if (m_timer == 0) m_mode = M_PLAY;
            end
         end
         default: ;
      endcase
   endtask

   // One clock: model consumes this cycle's inputs, DUT clocks, strobes drop afterwards.
   task automatic step();
      model_update();
      @(posedge vga_pix_clk);
      #1;
      frame_stb = 1'b0;
      ate_candy = 1'b0;
      ate_power = 1'b0;
   endtask

   task automatic frames(input int n, input int max_gap);
      for (int k = 0; k < n; k++) begin
         frame_stb = 1'b1;
         step();
         repeat ($urandom_range(0, max_gap)) step();
      end
   endtask

   task automatic do_reset();
      rst = 1'b1;
      step();
      step();
      rst = 1'b0;
   endtask

   task automatic scatter();
      for (int i = 0; i < NE; i++) begin
         enemy_x[i*CW +: CW] = CW'($urandom_range(200, 511));
         enemy_y[i*CW +: CW] = CW'($urandom_range(0, 511));
      end
   endtask

   task automatic put_enemy(input int i);
      enemy_x[i*CW +: CW] = x_pac;
      enemy_y[i*CW +: CW] = y_pac;
   endtask

   task automatic press();
      btn = 4'd0;
      step();
      btn = 4'(1 << $urandom_range(0, 3));
      step();
      btn = 4'd0;
   endtask

   task automatic boot_to_play();
      btn = 4'd0;
      scatter();
      do_reset();
      frames(LF, 0);
      press();
   endtask

   task automatic test_reset();
      btn = 4'b0001;
      scatter();
      do_reset();
      n_vec++; if (gif.mode !== 3'(M_LOADING)) begin n_err++; $display("FAIL reset_mode got %0d want %0d", gif.mode, M_LOADING); end
      n_vec++; if (gif.sound_type !== 3'(S_LOADING)) begin n_err++; $display("FAIL reset_sound got %0d want %0d", gif.sound_type, S_LOADING); end
      n_vec++; if (gif.score !== 16'd0) begin n_err++; $display("FAIL reset_score got %0d want 0", gif.score); end
      n_vec++; if (gif.lives !== 2'(LV)) begin n_err++; $display("FAIL reset_lives got %0d want %0d", gif.lives, LV); end
      n_vec++; if ({gif.frightened, gif.respawn_stb, gif.enemy_eaten_stb} !== 6'd0) begin n_err++;
         $display("FAIL reset_strobes got %b%b%b want 0", gif.frightened, gif.respawn_stb, gif.enemy_eaten_stb); end
      frame_stb = 1'b1;
      #1;
      n_vec++; if (gif.move_stb !== 1'b0) begin n_err++; $display("FAIL reset_move_stb got %b want 0", gif.move_stb); end
      step();
   endtask

   task automatic test_loading();
      btn = 4'b0001;
      do_reset();
      frames(LF - 1, 2);
      n_vec++; if (gif.mode !== 3'(M_LOADING)) begin n_err++; $display("FAIL loading_59 got %0d want %0d", gif.mode, M_LOADING); end
      frame_stb = 1'b1;
      step();
      n_vec++; if (gif.mode !== 3'(M_READY)) begin n_err++; $display("FAIL loading_60 got %0d want %0d", gif.mode, M_READY); end
      n_vec++; if (gif.sound_type !== 3'(S_LOADING)) begin n_err++; $display("FAIL sound_lag got %0d want %0d", gif.sound_type, S_LOADING); end
      step();
      n_vec++; if (gif.sound_type !== 3'(S_READY)) begin n_err++; $display("FAIL sound_ready got %0d want %0d", gif.sound_type, S_READY); end
      repeat (5) step();
      n_vec++; if (gif.mode !== 3'(M_READY)) begin n_err++; $display("FAIL held_btn got %0d want %0d", gif.mode, M_READY); end
      press();
      n_vec++; if (gif.mode !== 3'(M_PLAY)) begin n_err++; $display("FAIL press_start got %0d want %0d", gif.mode, M_PLAY); end
   endtask

   task automatic test_death();
      boot_to_play();
      put_enemy(2);
      step();
      n_vec++; if (gif.lives !== 2'd3 || gif.mode !== 3'(M_PLAY)) begin n_err++;
         $display("FAIL no_frame_hit got lives %0d mode %0d want 3 %0d", gif.lives, gif.mode, M_PLAY); end
      for (int k = 1; k <= LV; k++) begin
         put_enemy(2);
         frame_stb = 1'b1;
         #1;
         n_vec++; if (gif.move_stb !== 1'b1) begin n_err++; $display("FAIL play_move_stb got %b want 1", gif.move_stb); end
         step();
         n_vec++; if (gif.lives !== 2'(LV - k)) begin n_err++; $display("FAIL death_lives got %0d want %0d", gif.lives, LV - k); end
         n_vec++; if (gif.respawn_stb !== (k < LV)) begin n_err++; $display("FAIL death_respawn got %b want %b", gif.respawn_stb, k < LV); end
         n_vec++; if (gif.mode !== 3'((k < LV) ? M_READY : M_FAIL)) begin n_err++;
            $display("FAIL death_mode got %0d want %0d", gif.mode, (k < LV) ? M_READY : M_FAIL); end
         scatter();
         step();
         n_vec++; if (gif.respawn_stb !== 1'b0) begin n_err++; $display("FAIL respawn_width got %b want 0", gif.respawn_stb); end
         if (k < LV) press();
      end
      n_vec++; if (gif.sound_type !== 3'(S_FAIL)) begin n_err++; $display("FAIL fail_sound got %0d want %0d", gif.sound_type, S_FAIL); end
      press();
      frame_stb = 1'b1;
      #1;
      n_vec++; if (gif.move_stb !== 1'b0) begin n_err++; $display("FAIL fail_move_stb got %b want 0", gif.move_stb); end
      step();
      n_vec++; if (gif.mode !== 3'(M_FAIL)) begin n_err++; $display("FAIL fail_terminal got %0d want %0d", gif.mode, M_FAIL); end
   endtask

   task automatic test_fright();
      boot_to_play();
      ate_power = 1'b1;
      step();
      n_vec++; if (gif.mode !== 3'(M_BLUE) || gif.frightened !== 1'b1) begin n_err++;
         $display("FAIL blue_enter got %0d/%b want %0d/1", gif.mode, gif.frightened, M_BLUE); end
      put_enemy(0);
      put_enemy(3);
      frame_stb = 1'b1;
      step();
      n_vec++; if (gif.score !== 16'd20) begin n_err++; $display("FAIL ghost_score got %0d want 20", gif.score); end
      n_vec++; if (gif.enemy_eaten_stb !== 4'b1001) begin n_err++; $display("FAIL ghost_eaten got %b want 1001", gif.enemy_eaten_stb); end
      n_vec++; if (gif.lives !== 2'd3) begin n_err++; $display("FAIL ghost_lives got %0d want 3", gif.lives); end
      scatter();
      step();
      n_vec++; if (gif.enemy_eaten_stb !== 4'b0000) begin n_err++; $display("FAIL eaten_width got %b want 0000", gif.enemy_eaten_stb); end
      frames(FF - 2, 1);
      n_vec++; if (gif.mode !== 3'(M_BLUE)) begin n_err++; $display("FAIL fright_359 got %0d want %0d", gif.mode, M_BLUE); end
      frames(1, 0);
      n_vec++; if (gif.mode !== 3'(M_PLAY)) begin n_err++; $display("FAIL fright_360 got %0d want %0d", gif.mode, M_PLAY); end
   endtask

   task automatic test_fright_reload();
      ate_power = 1'b1;
      step();
      frames(200, 0);
      ate_power = 1'b1;
      step();
      frames(FF - 200, 0);
      n_vec++; if (gif.mode !== 3'(M_BLUE)) begin n_err++; $display("FAIL reload_360 got %0d want %0d", gif.mode, M_BLUE); end
      frames(199, 0);
      n_vec++; if (gif.mode !== 3'(M_BLUE)) begin n_err++; $display("FAIL reload_559 got %0d want %0d", gif.mode, M_BLUE); end
      frames(1, 0);
      n_vec++; if (gif.mode !== 3'(M_PLAY)) begin n_err++; $display("FAIL reload_560 got %0d want %0d", gif.mode, M_PLAY); end
   endtask

   task automatic test_power_beats_collision();
      put_enemy(1);
      frame_stb = 1'b1;
      ate_power = 1'b1;
      step();
      n_vec++; if (gif.mode !== 3'(M_BLUE) || gif.lives !== 2'd3 || gif.respawn_stb !== 1'b0 || gif.enemy_eaten_stb !== 4'd0) begin
         n_err++; $display("FAIL power_vs_hit got mode %0d lives %0d rsp %b eat %b want %0d 3 0 0000",
                           gif.mode, gif.lives, gif.respawn_stb, gif.enemy_eaten_stb, M_BLUE); end
      frame_stb = 1'b1;
      step();
      n_vec++; if (gif.enemy_eaten_stb !== 4'b0010 || gif.score !== 16'd30) begin n_err++;
         $display("FAIL next_frame_eat got %b/%0d want 0010/30", gif.enemy_eaten_stb, gif.score); end
   endtask

   task automatic test_reset_mid_blue();
      put_enemy(0);
      frame_stb = 1'b1;
      rst = 1'b1;
      step();
      rst = 1'b0;
      scatter();
      n_vec++; if (gif.mode !== 3'(M_LOADING) || gif.sound_type !== 3'(S_LOADING)) begin n_err++;
         $display("FAIL midrst_mode got %0d/%0d want %0d/%0d", gif.mode, gif.sound_type, M_LOADING, S_LOADING); end
      n_vec++; if (gif.score !== 16'd0 || gif.lives !== 2'd3) begin n_err++;
         $display("FAIL midrst_score got %0d/%0d want 0/3", gif.score, gif.lives); end
      n_vec++; if ({gif.frightened, gif.respawn_stb, gif.enemy_eaten_stb} !== 6'd0) begin n_err++;
         $display("FAIL midrst_strobes got %b%b%b want 0", gif.frightened, gif.respawn_stb, gif.enemy_eaten_stb); end
   endtask

   task automatic test_win();
      btn = 4'd0;
      scatter();
      do_reset();
      frames(LF, 0);
      ate_candy = 1'b1;
      step();
      n_vec++; if (gif.score !== 16'd0) begin n_err++; $display("FAIL candy_ready got %0d want 0", gif.score); end
      press();
      for (int k = 0; k < CC - 1; k++) begin
         ate_candy = 1'b1;
         step();
         repeat ($urandom_range(0, 2)) step();
      end
      n_vec++; if (gif.score !== 16'(CC - 1) || gif.mode !== 3'(M_PLAY)) begin n_err++;
         $display("FAIL pre_win got %0d/%0d want %0d/%0d", gif.score, gif.mode, CC - 1, M_PLAY); end
      put_enemy(2);
      frame_stb = 1'b1;
      ate_candy = 1'b1;
      step();
      scatter();
      n_vec++; if (gif.mode !== 3'(M_WIN) || gif.lives !== 2'd3 || gif.respawn_stb !== 1'b0) begin n_err++;
         $display("FAIL win_vs_hit got mode %0d lives %0d rsp %b want %0d 3 0", gif.mode, gif.lives, gif.respawn_stb, M_WIN); end
      step();
      n_vec++; if (gif.sound_type !== 3'(S_WIN)) begin n_err++; $display("FAIL win_sound got %0d want %0d", gif.sound_type, S_WIN); end
      frame_stb = 1'b1;
      #1;
      n_vec++; if (gif.move_stb !== 1'b0) begin n_err++; $display("FAIL win_move_stb got %b want 0", gif.move_stb); end
      step();
   endtask

   task automatic test_saturation();
      boot_to_play();
      for (int k = 0; k < 20; k++) begin
         ate_candy = 1'b1;
         step();
      end
      n_vec++; if (gif4.score !== 4'd15) begin n_err++; $display("FAIL score_sat4 got %0d want 15", gif4.score); end
      n_vec++; if (gif.score !== 16'd20) begin n_err++; $display("FAIL score_wide got %0d want 20", gif.score); end
   endtask

   task automatic test_random();
      boot_to_play();
      for (int c = 0; c < 3000; c++) begin
         if (m_mode == M_FAIL || m_mode == M_WIN) rst = ($urandom_range(0, 15) == 0);
         else rst = ($urandom_range(0, 999) == 0);
         frame_stb = ($urandom_range(0, 3) == 0);
         ate_candy = ($urandom_range(0, 9) == 0);
         ate_power = ($urandom_range(0, 79) == 0);
         if ($urandom_range(0, 5) == 0) btn = 4'($urandom_range(0, 15));
         for (int i = 0; i < NE; i++) begin
            if ($urandom_range(0, 39) == 0) put_enemy(i);
            else begin
               enemy_x[i*CW +: CW] = CW'($urandom_range(200, 511));
               enemy_y[i*CW +: CW] = CW'($urandom_range(0, 511));
            end
         end
         #1;
         n_vec++; if (gif.move_stb !== (frame_stb && (m_mode == M_PLAY || m_mode == M_BLUE))) begin n_err++;
            $display("FAIL rnd_move_stb cyc %0d got %b want %b", c, gif.move_stb, frame_stb && (m_mode == M_PLAY || m_mode == M_BLUE)); end
         step();
         rst = 1'b0;
         n_vec++; if (gif.mode !== 3'(m_mode) || gif.sound_type !== 3'(m_sound)) begin n_err++;
            $display("FAIL rnd_mode cyc %0d got %0d/%0d want %0d/%0d", c, gif.mode, gif.sound_type, m_mode, m_sound); end
         n_vec++; if (gif.score !== 16'(m_score) || gif.lives !== 2'(m_lives)) begin n_err++;
            $display("FAIL rnd_score cyc %0d got %0d/%0d want %0d/%0d", c, gif.score, gif.lives, m_score, m_lives); end
         n_vec++; if (gif.enemy_eaten_stb !== m_eaten || gif.respawn_stb !== m_respawn
                      || gif.frightened !== (m_mode == M_BLUE)) begin n_err++;
            $display("FAIL rnd_strobes cyc %0d got %b/%b/%b want %b/%b/%b", c, gif.enemy_eaten_stb, gif.respawn_stb,
                     gif.frightened, m_eaten, m_respawn, m_mode == M_BLUE); end
      end
   endtask

   initial begin
      test_reset();
      test_loading();
      test_death();
      test_fright();
      test_fright_reload();
      test_power_beats_collision();
      test_reset_mid_blue();
      test_win();
      test_saturation();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
